// File: rtl/color_move_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// color_move_ctrl : bounces the colour-window origin around the active area,
//                   committing new positions only at frame starts.  Rev 1.0
// ----------------------------------------------------------------------------
module color_move_ctrl #(
   parameter int H_DIS     = 1280,
   parameter int V_DIS     = 720,
   parameter int WIN_H     = 320,
   parameter int WIN_V     = 180,
   parameter int STEP_W    = 4,
   parameter bit VS_POL    = 1'b1,
   parameter int FRAME_DIV = 1
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_vs,
   input  logic              i_en,
   input  logic [STEP_W-1:0] i_step_x,
   input  logic [STEP_W-1:0] i_step_y,
   input  logic              i_cfg_load,
   input  logic [10:0]       i_cfg_x0,
   input  logic [10:0]       i_cfg_y0,
   output logic [10:0]       o_start_x,
   output logic [10:0]       o_start_y,
   output logic              o_dir_x,
   output logic              o_dir_y,
   output logic              o_frame_tick,
   output logic              o_bounce,
   output logic              o_busy
);

   localparam logic [10:0] X_MAX = 11'(H_DIS - WIN_H);
   localparam logic [10:0] Y_MAX = 11'(V_DIS - WIN_V);
   localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LOAD = 2'd2
   } state_t;

   state_t           state;
   logic             vs_d1;
   logic             vs_d2;
   logic [DIV_W-1:0] div_cnt;
   logic [10:0]      pend_x;
   logic [10:0]      pend_y;
   logic [12:0]      nxt_x;
   logic [12:0]      nxt_y;

   // Returns {bounce, dir, pos}; a zero step or a zero limit leaves the axis untouched.
   function automatic logic [12:0] step_axis(
      input logic [10:0]       pos,
      input logic              dir,
      input logic [STEP_W-1:0] step,
      input logic [10:0]       lim
   );
      logic [11:0] sum;
      sum = {1'b0, pos} + 12'(step);
      if (lim == 11'd0 || step == '0)
         step_axis = {1'b0, dir, pos};
      else if (!dir) begin
         if (sum >= {1'b0, lim})
            step_axis = {1'b1, 1'b1, lim};
         else
            step_axis = {1'b0, 1'b0, sum[10:0]};
      end else begin
         if (pos <= 11'(step))
            step_axis = {1'b1, 1'b0, 11'd0};
         else
            step_axis = {1'b0, 1'b1, pos - 11'(step)};
      end
   endfunction

   always_comb begin
      nxt_x = step_axis(o_start_x, o_dir_x, i_step_x, X_MAX);
      nxt_y = step_axis(o_start_y, o_dir_y, i_step_y, Y_MAX);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= IDLE;
         vs_d1        <= 1'b0;
         vs_d2        <= 1'b0;
         div_cnt      <= '0;
         pend_x       <= '0;
         pend_y       <= '0;
         o_start_x    <= '0;
         o_start_y    <= '0;
         o_dir_x      <= 1'b0;
         o_dir_y      <= 1'b0;
         o_frame_tick <= 1'b0;
         o_bounce     <= 1'b0;
         o_busy       <= 1'b0;
      end else begin
         vs_d1        <= (i_vs == VS_POL);
         vs_d2        <= vs_d1;
         o_frame_tick <= vs_d1 & ~vs_d2;
         o_bounce     <= 1'b0;

         if (o_frame_tick) begin
            if (state == LOAD) begin
               // A load arriving on the tick itself is deferred to the following tick.
               if (!i_cfg_load) begin
                  o_start_x <= pend_x;
                  o_start_y <= pend_y;
                  o_dir_x   <= 1'b0;
                  o_dir_y   <= 1'b0;
                  o_busy    <= 1'b0;
                  div_cnt   <= '0;
                  state     <= i_en ? RUN : IDLE;
               end
            end else if (div_cnt == DIV_LAST) begin
               div_cnt <= '0;
               if (i_en) begin
                  o_start_x <= nxt_x[10:0];
                  o_dir_x   <= nxt_x[11];
                  o_start_y <= nxt_y[10:0];
                  o_dir_y   <= nxt_y[11];
                  o_bounce  <= nxt_x[12] | nxt_y[12];
                  state     <= RUN;
               end else begin
                  state <= IDLE;
               end
            end else begin
               div_cnt <= div_cnt + DIV_W'(1);
            end
         end

         if (i_cfg_load) begin
            pend_x <= (i_cfg_x0 > X_MAX) ? X_MAX : i_cfg_x0;
            pend_y <= (i_cfg_y0 > Y_MAX) ? Y_MAX : i_cfg_y0;
            o_busy <= 1'b1;
            state  <= LOAD;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_color_move_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_color_move_ctrl : frame-level scoreboard bench for color_move_ctrl.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_color_move_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        vs;
   logic        en;
   logic [3:0]  step_x;
   logic [3:0]  step_y;
   logic        cfg_load;
   logic [10:0] cfg_x0;
   logic [10:0] cfg_y0;

   logic [10:0] sx1, sy1, sx4, sy4;
   logic        dx1, dy1, tick1, bnc1, busy1;
   logic        dx4, dy4, tick4, bnc4, busy4;

   color_move_ctrl dut1 (
      .i_clk(clk), .i_rst(rst), .i_vs(vs), .i_en(en),
      .i_step_x(step_x), .i_step_y(step_y),
      .i_cfg_load(cfg_load), .i_cfg_x0(cfg_x0), .i_cfg_y0(cfg_y0),
      .o_start_x(sx1), .o_start_y(sy1), .o_dir_x(dx1), .o_dir_y(dy1),
      .o_frame_tick(tick1), .o_bounce(bnc1), .o_busy(busy1)
   );

   color_move_ctrl #(.FRAME_DIV(4)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_vs(vs), .i_en(en),
      .i_step_x(step_x), .i_step_y(step_y),
      .i_cfg_load(cfg_load), .i_cfg_x0(cfg_x0), .i_cfg_y0(cfg_y0),
      .o_start_x(sx4), .o_start_y(sy4), .o_dir_x(dx4), .o_dir_y(dy4),
      .o_frame_tick(tick4), .o_bounce(bnc4), .o_busy(busy4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [3:0]  sx;
      logic [3:0]  sy;
      logic        ld;
      logic [10:0] x0;
      logic [10:0] y0;
      int          ex;
      int          ey;
      int          edx;
      int          edy;
      int          eb;
   } vec_t;

   typedef struct {
      int x;
      int y;
      int dx;
      int dy;
      int b;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[17];
   int   n_vec = 0;
   int   n_bad = 0;
   int   tick_cnt = 0;
   int   tick4_cnt = 0;
   int   tc0;
   int   last_x;
   int   ex4[11];
   int   ey4[11];

   always @(negedge clk) begin
      if (tick1) tick_cnt++;
      if (tick4) tick4_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic e, input int sx, input int sy, input logic ld,
                               input int x0, input int y0, input int ex, input int ey,
                               input int edx, input int edy, input int eb);
      vec_t v;
      v.en = e; v.sx = 4'(sx); v.sy = 4'(sy); v.ld = ld;
      v.x0 = 11'(x0); v.y0 = 11'(y0);
      v.ex = ex; v.ey = ey; v.edx = edx; v.edy = edy; v.eb = eb;
      return v;
   endfunction

   task automatic mdl(inout int p, inout int d, inout int b, input int s, input int mx);
      if (s != 0 && mx != 0) begin
         if (d == 0) begin
            if (p + s >= mx) begin p = mx; d = 1; b = 1; end
            else p = p + s;
         end else begin
            if (p <= s) begin p = 0; d = 0; b = 1; end
            else p = p - s;
         end
      end
   endtask

   // Leaves the caller just past the update edge, where new values are visible.
   task automatic frame_start(input bit do_load, input int prev_x);
      bit seen;
      int waits;
      if (do_load) begin
         @(negedge clk); cfg_load = 1'b1;
         @(negedge clk); cfg_load = 1'b0;
         chk("busy_pending", int'(busy1), 1);
      end
      @(negedge clk);
      tc0 = tick_cnt;
      vs = 1'b1;
      seen = 1'b0;
      waits = 0;
      while (!seen && waits < 8) begin
         @(negedge clk);
         waits++;
         if (tick1) seen = 1'b1;
      end
      chk("tick_latency", seen ? waits : -1, 2);
      chk("hold_before_update", int'(sx1), prev_x);
      @(posedge clk);
      #1;
   endtask

   task automatic frame_end();
      repeat (5) @(negedge clk);
      vs = 1'b0;
      repeat (8) @(negedge clk);
      chk("ticks_per_frame", tick_cnt - tc0, 1);
   endtask

   initial begin
      exp_t e;
      int mx, my, mdx, mdy, mb;

      rst = 1'b1; vs = 1'b0; en = 1'b0; step_x = '0; step_y = '0;
      cfg_load = 1'b0; cfg_x0 = '0; cfg_y0 = '0;
      repeat (3) @(negedge clk);
      chk("rst_start_x", int'(sx1), 0);
      chk("rst_start_y", int'(sy1), 0);
      chk("rst_dir_x", int'(dx1), 0);
      chk("rst_dir_y", int'(dy1), 0);
      chk("rst_tick", int'(tick1), 0);
      chk("rst_bounce", int'(bnc1), 0);
      chk("rst_busy", int'(busy1), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      //          en sx sy ld  x0    y0    ex   ey   dx dy b
      tbl[0]  = mk(0, 4, 2, 0, 0,    0,    0,   0,   0, 0, 0);
      tbl[1]  = mk(0, 4, 2, 0, 0,    0,    0,   0,   0, 0, 0);
      tbl[2]  = mk(0, 4, 2, 0, 0,    0,    0,   0,   0, 0, 0);
      tbl[3]  = mk(1, 4, 2, 0, 0,    0,    4,   2,   0, 0, 0);
      tbl[4]  = mk(1, 4, 2, 0, 0,    0,    8,   4,   0, 0, 0);
      tbl[5]  = mk(1, 4, 2, 0, 0,    0,    12,  6,   0, 0, 0);
      tbl[6]  = mk(1, 10, 2, 1, 955, 100,  955, 100, 0, 0, 0);
      tbl[7]  = mk(1, 10, 2, 0, 0,   0,    960, 102, 1, 0, 1);
      tbl[8]  = mk(1, 10, 2, 0, 0,   0,    950, 104, 1, 0, 0);
      tbl[9]  = mk(1, 10, 2, 1, 2000, 900, 960, 540, 0, 0, 0);
      tbl[10] = mk(1, 10, 2, 0, 0,   0,    960, 540, 1, 1, 1);
      tbl[11] = mk(1, 10, 2, 0, 0,   0,    950, 538, 1, 1, 0);
      tbl[12] = mk(1, 0, 0, 0, 0,    0,    950, 538, 1, 1, 0);
      tbl[13] = mk(0, 15, 15, 0, 0,  0,    950, 538, 1, 1, 0);
      tbl[14] = mk(1, 15, 15, 1, 955, 535, 955, 535, 0, 0, 0);
      tbl[15] = mk(1, 15, 15, 0, 0,  0,    960, 540, 1, 1, 1);
      tbl[16] = mk(1, 15, 15, 0, 0,  0,    945, 525, 1, 1, 0);

      last_x = 0;
      for (int i = 0; i < 17; i++) begin
         en = tbl[i].en; step_x = tbl[i].sx; step_y = tbl[i].sy;
         cfg_x0 = tbl[i].x0; cfg_y0 = tbl[i].y0;
         sb.push_back('{tbl[i].ex, tbl[i].ey, tbl[i].edx, tbl[i].edy, tbl[i].eb});
         frame_start(tbl[i].ld, last_x);
         e = sb.pop_front();
         chk("tbl_start_x", int'(sx1), e.x);
         chk("tbl_start_y", int'(sy1), e.y);
         chk("tbl_dir_x", int'(dx1), e.dx);
         chk("tbl_dir_y", int'(dy1), e.dy);
         chk("tbl_bounce", int'(bnc1), e.b);
         chk("tbl_busy", int'(busy1), 0);
         last_x = e.x;
         frame_end();
      end

      // Long run down to the left/top edges with the largest step.
      mx = 945; my = 525; mdx = 1; mdy = 1;
      en = 1'b1; step_x = 4'd15; step_y = 4'd15;
      for (int f = 0; f < 64; f++) begin
         mb = 0;
         mdl(mx, mdx, mb, 15, 960);
         mdl(my, mdy, mb, 15, 540);
         sb.push_back('{mx, my, mdx, mdy, mb});
         frame_start(1'b0, last_x);
         e = sb.pop_front();
         chk("run_start_x", int'(sx1), e.x);
         chk("run_start_y", int'(sy1), e.y);
         chk("run_dir_x", int'(dx1), e.dx);
         chk("run_dir_y", int'(dy1), e.dy);
         chk("run_bounce", int'(bnc1), e.b);
         last_x = e.x;
         frame_end();
      end

      // Divided update rate, with a load landing mid-count.
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      ex4 = '{0, 0, 0, 1, 1, 1, 100, 100, 100, 100, 101};
      ey4 = '{0, 0, 0, 1, 1, 1, 50, 50, 50, 50, 51};
      en = 1'b1; step_x = 4'd1; step_y = 4'd1; cfg_x0 = 11'd100; cfg_y0 = 11'd50;
      mx = 0; my = 0; mdx = 0; mdy = 0; last_x = 0;
      for (int f = 0; f < 11; f++) begin
         mb = 0;
         if (f == 6) begin
            mx = 100; my = 50; mdx = 0; mdy = 0;
         end else begin
            mdl(mx, mdx, mb, 1, 960);
            mdl(my, mdy, mb, 1, 540);
         end
         sb.push_back('{ex4[f], ey4[f], 0, 0, 0});
         frame_start(f == 6, last_x);
         e = sb.pop_front();
         chk("div4_start_x", int'(sx4), e.x);
         chk("div4_start_y", int'(sy4), e.y);
         chk("div4_dir_x", int'(dx4), e.dx);
         chk("div4_bounce", int'(bnc4), e.b);
         chk("div4_busy", int'(busy4), 0);
         chk("div1_start_x", int'(sx1), mx);
         chk("div1_start_y", int'(sy1), my);
         last_x = mx;
         frame_end();
      end
      chk("div4_ticks", tick4_cnt - tick_cnt, 0);

      // Reset while a load is pending: pending value must be discarded.
      cfg_x0 = 11'd300; cfg_y0 = 11'd200;
      @(negedge clk); cfg_load = 1'b1;
      @(negedge clk); cfg_load = 1'b0;
      chk("busy_before_rst", int'(busy1), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_x", int'(sx1), 0);
      chk("async_rst_y", int'(sy1), 0);
      chk("async_rst_dir_y", int'(dy1), 0);
      chk("async_rst_busy", int'(busy1), 0);
      chk("async_rst_busy4", int'(busy4), 0);
      @(negedge clk); rst = 1'b0;
      en = 1'b0;
      last_x = 0;
      for (int f = 0; f < 2; f++) begin
         frame_start(1'b0, last_x);
         chk("post_rst_x", int'(sx1), 0);
         chk("post_rst_y", int'(sy1), 0);
         chk("post_rst_busy", int'(busy1), 0);
         frame_end();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/color_move_ctrl.md
Name: color_move_ctrl

Overview:
- Frame-synchronous controller that drives the window origin of the colour-window timing generator (START_X / START_Y inputs) so the window bounces around the active area.
- Sits between the register/config side and the timing block. It takes that block's vertical sync and returns the window position.
- New positions take effect only at frame boundaries, so a window never tears mid-frame.

Parameters:
- H_DIS, 1280, active width in pixels.
- V_DIS, 720, active height in lines.
- WIN_H, 320, window width; must satisfy WIN_H <= H_DIS.
- WIN_V, 180, window height; must satisfy WIN_V <= V_DIS.
- STEP_W, 4, width of the step inputs.
- VS_POL, 1, asserted level of i_vs.
- FRAME_DIV, 1, number of frames between position updates; must be >= 1.

Ports:
- i_clk  in  1  pixel clock, same clock as the timing generator.
- i_rst  in  1  asynchronous, active-high reset.
- i_vs  in  1  vertical sync from the timing generator.
- i_en  in  1  1 = move each update; 0 = freeze position.
- i_step_x  in  STEP_W  horizontal step per update, in pixels.
- i_step_y  in  STEP_W  vertical step per update, in lines.
- i_cfg_load  in  1  one-cycle pulse; requests a new origin.
- i_cfg_x0  in  11  requested X origin.
- i_cfg_y0  in  11  requested Y origin.
- o_start_x  out  11  window X origin.
- o_start_y  out  11  window Y origin.
- o_dir_x  out  1  0 = moving right, 1 = moving left.
- o_dir_y  out  1  0 = moving down, 1 = moving up.
- o_frame_tick  out  1  one-cycle pulse per detected frame start.
- o_bounce  out  1  one-cycle pulse when either axis reflects.
- o_busy  out  1  a cfg load is pending.

Behaviour:
- Reset (async, i_rst=1): all outputs 0. Internal state cleared: vs pipeline, divider, pending flag, and the FSM goes to IDLE.
- Limits: X_MAX = H_DIS-WIN_H, Y_MAX = V_DIS-WIN_V, both constants.
- Frame detect:
  - vs_d1 <= (i_vs==VS_POL); vs_d2 <= vs_d1.
  - o_frame_tick <= vs_d1 & ~vs_d2.
  - If clock edge k is the first to sample asserted i_vs, o_frame_tick is high for the cycle after edge k+1.
- Update point: div_cnt counts ticks from 0 to FRAME_DIV-1. The update edge is the tick cycle in which div_cnt==FRAME_DIV-1; div_cnt wraps to 0 on that edge.
  - Positions and directions change only on update edges, so o_start_x/y change at edge k+2.
- FSM states:
  - IDLE: entered on reset or when i_en=0 at an update edge. Position held. Goes to RUN at the first update edge with i_en=1; that edge also performs the move.
  - RUN: moves one step per update edge.
  - LOAD: entered whenever a cfg load is pending. Exits at the next tick, regardless of div_cnt, to RUN if i_en=1 or IDLE otherwise.
- Cfg load:
  - i_cfg_load captures x0/y0 into pending registers and sets o_busy.
  - Values are clamped: x0>X_MAX gives X_MAX; y0>Y_MAX gives Y_MAX.
  - On the next tick: start_x/y <= pending values, dir_x=dir_y=0, o_busy cleared, div_cnt reset to 0, and no step is applied that tick.
  - A new i_cfg_load while pending overwrites the pending values (last wins).
  - i_cfg_load in the same cycle as a tick is captured but applied at the following tick.
- Move, X axis (Y is identical using Y_MAX and i_step_y):
  - dir 0: if x+step >= X_MAX then x=X_MAX, dir=1, bounce; else x=x+step.
  - dir 1: if x <= step then x=0, dir=0, bounce; else x=x-step.
  - Compute x+step at 12 bits so it cannot overflow.
- Zero step: no movement, no bounce, direction kept.
- o_bounce: registered, high for 1 cycle on the update edge if X and/or Y reflected (X and Y bouncing together gives one pulse).
- Degenerate limit: when X_MAX=0, start_x stays 0 permanently and dir_x never toggles (Y likewise).
- Step inputs and i_en are sampled only on update edges; changing them mid-frame has no effect until then.
- If i_vs is held asserted, no further ticks are produced until it deasserts and reasserts.
- Reset during a load or a move clears everything immediately. After reset deasserts, no move happens before the first full tick.

Test Plan:
- Reset then 3 frames with i_en=0 -> o_start_x/y stay 0, o_frame_tick pulses 3 times at edge k+1 after each vs rise, o_bounce never.
- i_en=1, step_x=4, step_y=2, FRAME_DIV=1 -> after 3 frames start=(12,6); o_start updates exactly 2 edges after the first edge sampling asserted vs.
- Load x0=955, step_x=10 (X_MAX=960) -> next update gives x=960, dir_x=1, o_bounce=1; the following update gives x=950.
- Load x0=2000, y0=900 -> o_busy=1 until the next tick; then start=(960,540), dirs 0, no step that frame.
- FRAME_DIV=4, step_x=1 -> x increments once per 4 ticks; a load issued mid-count applies on the next tick and resets div_cnt.
- Assert i_rst for 1 cycle mid-frame while a load is pending -> outputs 0 asynchronously, o_busy=0; the pending value is discarded and never applied.
